// File: rtl/im_fetch_ctrl.sv
// Purpose : fetch initiator for an asynchronous instruction memory; owns the PC,
//           drives CSB/WRB/ABUS, samples DATABUS after WAIT_CYCLES edges.
// Latency : instr_valid rises WAIT_CYCLES edges after the edge that launches the
//           access; one instruction per WAIT_CYCLES+1 cycles with instr_ready high.
// Backpressure: a held instruction (and the bus) stays frozen until instr_ready;
//           redirect drops it and restarts from redirect_pc.
// Ports   : clk/rst (async active-high); en, redirect, redirect_pc from the core;
//           instr_valid/instr_ready/instr/instr_pc to decode; busy status;
//           CSB/WRB/ABUS/DATABUS to the memory (DATABUS is input only).
module im_fetch_ctrl #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 8,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy,
  output logic              CSB,
  output logic              WRB,
  output logic [ADDR_W-1:0] ABUS,
  input  logic [DATA_W-1:0] DATABUS
);

  localparam int              CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      CSB         <= 1'b1;
      WRB         <= 1'b1;
      ABUS        <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      cnt         <= '0;
      busy        <= 1'b0;
    end else if (redirect) begin
      // Redirect aborts whatever is in flight or held; no capture happens.
      pc          <= redirect_pc;
      instr_valid <= 1'b0;
      if (en) begin
        state <= ACCESS;
        ABUS  <= redirect_pc;
        CSB   <= 1'b0;
        cnt   <= CNT_INIT;
        busy  <= 1'b1;
      end else begin
        state <= IDLE;
        CSB   <= 1'b1;
        cnt   <= '0;
        busy  <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          CSB <= 1'b1;
          if (en) begin
            state <= ACCESS;
            ABUS  <= pc;
            CSB   <= 1'b0;
            cnt   <= CNT_INIT;
            busy  <= 1'b1;
          end
        end
        ACCESS: begin
          cnt <= cnt - CNT_W'(1);
          // Last wait edge: memory output has settled, capture it.
          if (cnt == CNT_W'(1)) begin
            instr       <= DATABUS;
            instr_pc    <= ABUS;
            instr_valid <= 1'b1;
            pc          <= ABUS + ADDR_W'(1);
            state       <= HOLD;
          end
        end
        HOLD: begin
          // en only matters once the held instruction has been taken.
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            if (en) begin
              state <= ACCESS;
              ABUS  <= pc;
              cnt   <= CNT_INIT;
            end else begin
              state <= IDLE;
              CSB   <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          CSB   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_fetch_ctrl.sv
module tb_im_fetch_ctrl;

  localparam int W = 2;

  logic       clk;
  logic       rst;
  logic       en;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       busy;
  logic       CSB;
  logic       WRB;
  logic [7:0] ABUS;
  wire  [7:0] DATABUS;

  logic [7:0] mem [256];

  int n_cmp;
  int n_err;

  // Asynchronous memory: data follows the address while selected.
  assign DATABUS = CSB ? 8'hzz : mem[ABUS];

  im_fetch_ctrl #(
    .ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(W), .RESET_PC(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .busy(busy), .CSB(CSB), .WRB(WRB), .ABUS(ABUS),
    .DATABUS(DATABUS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: transaction/timestamp view of the fetch engine.
  bit         m_active;   // an access is in flight or its result is held
  bit         m_held;     // an instruction is being presented
  int         m_due;      // edge index on which the in-flight data is captured
  logic [7:0] m_pc;       // address the next presented instruction must carry
  int         edge_no;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0; en = 1'b0; redirect = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'hA5; mem[8'h01] = 8'h3C; mem[8'h02] = 8'h11; mem[8'h03] = 8'h22;
    mem[8'h05] = 8'h5A; mem[8'h07] = 8'h99; mem[8'h10] = 8'hE1; mem[8'h40] = 8'hC3;
    mem[8'hFF] = 8'h77;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst_csb", CSB, 1);
    chk("rst_wrb", WRB, 1);
    chk("rst_abus", ABUS, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_ipc", instr_pc, 0);
    chk("rst_busy", busy, 0);
    step();
    rst = 1'b0; en = 1'b1; instr_ready = 1'b1;

    // Basic fetch: A5 then 3C, one every W+1 cycles
    step();
    chk("t1_csb", CSB, 0);
    chk("t1_abus", ABUS, 8'h00);
    chk("t1_busy", busy, 1);
    chk("t1_valid_e1", instr_valid, 0);
    step();
    chk("t1_valid_e2", instr_valid, 0);
    step();
    chk("t1_valid_e3", instr_valid, 1);
    chk("t1_instr0", instr, 8'hA5);
    chk("t1_ipc0", instr_pc, 8'h00);
    step();
    chk("t1_valid_e4", instr_valid, 0);
    chk("t1_abus1", ABUS, 8'h01);
    step(); step();
    chk("t1_valid_e6", instr_valid, 1);
    chk("t1_instr1", instr, 8'h3C);
    chk("t1_ipc1", instr_pc, 8'h01);

    // Backpressure: held instruction and bus frozen
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_instr", instr, 8'h3C);
      chk("t2_valid", instr_valid, 1);
      chk("t2_abus", ABUS, 8'h01);
      chk("t2_csb", CSB, 0);
    end
    instr_ready = 1'b1;
    step();
    chk("t2_rel_valid", instr_valid, 0);
    chk("t2_rel_abus", ABUS, 8'h02);
    chk("t2_rel_csb", CSB, 0);
    step(); step();
    chk("t2_next_instr", instr, 8'h11);
    chk("t2_next_ipc", instr_pc, 8'h02);

    // en low: drain to IDLE after the handshake
    en = 1'b0;
    step();
    chk("t2b_idle_csb", CSB, 1);
    chk("t2b_idle_busy", busy, 0);
    step();
    chk("t2b_stay_csb", CSB, 1);
    // en falling mid-access: access still completes
    en = 1'b1;
    step();
    chk("t2b_abus3", ABUS, 8'h03);
    en = 1'b0;
    step(); step();
    chk("t2b_drain_valid", instr_valid, 1);
    chk("t2b_drain_instr", instr, 8'h22);
    step();
    chk("t2b_drain_csb", CSB, 1);
    chk("t2b_drain_busy", busy, 0);
    chk("t2b_drain_vld0", instr_valid, 0);

    // Wrap from FF to 00
    en = 1'b1; redirect = 1'b1; redirect_pc = 8'hFF; instr_ready = 1'b0;
    step();
    chk("t3_abus_ff", ABUS, 8'hFF);
    chk("t3_csb", CSB, 0);
    redirect = 1'b0;
    step(); step();
    chk("t3_instr_ff", instr, 8'h77);
    chk("t3_ipc_ff", instr_pc, 8'hFF);
    instr_ready = 1'b1;
    step();
    chk("t3_abus_00", ABUS, 8'h00);
    step(); step();
    chk("t3_instr_00", instr, 8'hA5);
    chk("t3_ipc_00", instr_pc, 8'h00);

    // Redirect mid-access: 05 is never presented
    redirect = 1'b1; redirect_pc = 8'h05; instr_ready = 1'b0;
    step();
    chk("t4_abus05", ABUS, 8'h05);
    redirect_pc = 8'h40;
    step();
    chk("t4_abus40", ABUS, 8'h40);
    chk("t4_valid_a", instr_valid, 0);
    redirect = 1'b0;
    step();
    chk("t4_valid_b", instr_valid, 0);
    step();
    chk("t4_valid_c", instr_valid, 1);
    chk("t4_instr40", instr, 8'hC3);
    chk("t4_ipc40", instr_pc, 8'h40);

    // Redirect in the same edge as a handshake: held instr dropped
    redirect = 1'b1; redirect_pc = 8'h10; instr_ready = 1'b1;
    step();
    chk("t5_valid", instr_valid, 0);
    chk("t5_abus", ABUS, 8'h10);
    redirect = 1'b0; instr_ready = 1'b0;
    step(); step();
    chk("t5_instr", instr, 8'hE1);
    chk("t5_ipc", instr_pc, 8'h10);

    // Asynchronous reset mid-access
    redirect = 1'b1; redirect_pc = 8'h07;
    step();
    chk("t6_abus07", ABUS, 8'h07);
    redirect = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_csb", CSB, 1);
    chk("t6_valid", instr_valid, 0);
    chk("t6_abus", ABUS, 8'h00);
    chk("t6_busy", busy, 0);
    #1 rst = 1'b0;
    step();
    chk("t6_restart_abus", ABUS, 8'h00);
    chk("t6_restart_csb", CSB, 0);
    step(); step();
    chk("t6_instr", instr, 8'hA5);
    chk("t6_ipc", instr_pc, 8'h00);

    // Randomized run against the reference model
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    en = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    m_active = 1'b0; m_held = 1'b0; m_due = 0; m_pc = 8'h00; edge_no = 0;
    for (int t = 0; t < 800; t++) begin
      en          = ($urandom_range(0, 7) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = 8'($urandom);
      edge_no++;
      if (redirect) begin
        m_held   = 1'b0;
        m_pc     = redirect_pc;
        m_active = en;
        m_due    = edge_no + W;
      end else if (m_held) begin
        if (instr_ready) begin
          m_held   = 1'b0;
          m_pc     = m_pc + 8'd1;
          m_active = en;
          m_due    = edge_no + W;
        end
      end else if (m_active) begin
        if (edge_no == m_due) m_held = 1'b1;
      end else if (en) begin
        m_active = 1'b1;
        m_due    = edge_no + W;
      end
      step();
      chk("rnd_valid", instr_valid, m_held);
      chk("rnd_busy", busy, m_active);
      chk("rnd_csb", CSB, !m_active);
      chk("rnd_wrb", WRB, 1);
      if (m_active) chk("rnd_abus", ABUS, m_pc);
      if (m_held) begin
        chk("rnd_instr", instr, mem[m_pc]);
        chk("rnd_ipc", instr_pc, m_pc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
